sw_calib_ctrl: RTL
==================

// Module: sw_calib_ctrl
// PURPOSE
// - Front-panel switch/button controller for multi-channel DAC calibration and encoder RPM-range selection.
// - Debounces raw switches and buttons, runs the calibration mode FSM and steps per-channel origin/10V-width with auto-repeat.
// - Outputs registered values straight to the DAC scaling path; replaces the fixed 2-value, free-running-increment scheme.
// PARAMETERS
// - NCH        2         number of DAC channels calibrated (>=1); CH_W = max(1,$clog2(NCH))
// - DAC_W      16        DAC code width
// - CLK_HZ     60000000  CLK_60 frequency
// - TICK_HZ    1000      step/debounce tick rate; TICK_DIV = CLK_HZ/TICK_HZ
// - DEB_TICKS  20        ticks an input must be stable before its debounced value changes
// - REP_TICKS  500       ticks a button must be held before auto-repeat starts
// - ORG_DEF    32768     reset origin code, every channel
// - WID_DEF    27692     reset 10V-width code, every channel
// - CAL_SPAN   5000      +/- calibration range around ORG_DEF and WID_DEF
// PORTS
// - CLK_60     in   1          system clock
// - RST_N      in   1          synchronous reset, active-low
// - SW         in   8          raw switches, SW[0]=SW1 .. SW[7]=SW8
// - BTN_UP     in   1          raw step-up button, active-high
// - BTN_DN     in   1          raw step-down button, active-high
// - CH_SEL     in   CH_W       channel to calibrate, latched on entering a CAL state
// - dac_org    out  NCH*DAC_W  per-channel origin, ch k at [k*DAC_W +: DAC_W]
// - dac_width  out  NCH*DAC_W  per-channel 10V width, same packing
// - rpm_range  out  16         RPM full-scale selection
// - calib_org  out  1          high in CAL_ORG
// - calib_10V  out  1          high in CAL_WID
// - cal_step   out  1          1-cycle pulse when a calibration value changed
// BEHAVIOUR
// - Reset (RST_N=0 at edge): all dac_org=ORG_DEF, dac_width=WID_DEF, rpm_range=400, calib_*=0, cal_step=0, FSM=IDLE, debounced inputs=0, counters=0.
// - Tick: counter 0..TICK_DIV-1; tick is a 1-cycle pulse on terminal count.
// - Debounce: each of SW[7:0], BTN_UP, BTN_DN goes through 2-FF sync; debounced value updates after DEB_TICKS consecutive ticks with sync value != debounced value; any mismatch-free tick resets its count.
// - FSM from debounced {SW8,SW7}: 2'b01 -> CAL_ORG, 2'b11 -> CAL_WID, else IDLE. Any state reachable from any state in one cycle.
// - On entry to CAL_ORG/CAL_WID from another state: latch CH_SEL (CH_SEL>=NCH latches NCH-1), clear repeat counter. CH_SEL ignored while in a CAL state.
// - Step request: rising edge of debounced UP (or DN) = one step; while held, after REP_TICKS ticks one step per tick. UP and DN both high: no step, repeat counter held at 0.
// - Step applied the cycle after the request to the latched channel; IDLE ignores buttons. cal_step pulses in the same cycle as the register update, only if the value changed.
// - Arithmetic in DAC_W+1 bits: org range [ORG_DEF-CAL_SPAN, ORG_DEF+CAL_SPAN], width range [WID_DEF-CAL_SPAN, WID_DEF+CAL_SPAN], and org+width <= 2^DAC_W-1 always; a step that would violate any bound is dropped (saturate), cal_step stays 0.
// - rpm_range from debounced {SW6,SW5},{SW4,SW3}: 00 -> 400/900/1800/3600; 01 -> 1250/2500/5000/10000 (index {SW4,SW3}=00..11); {SW6,SW5}=1x holds previous value. Updated every cycle, any state.
// - calib_org/calib_10V registered, equal to FSM state; never both high.
// - Reset mid-step or mid-debounce: all pending steps/counts discarded, defaults restored next cycle.
// CONFIGURATION
// - CAL_WRAP_EN defined: a step past the upper span bound loads the lower span bound and vice versa (legacy wrap); the org+width <= 2^DAC_W-1 limit still saturates; cal_step pulses on wrap.
// - CAL_WRAP_EN undefined: pure saturation as above.
// TESTING (sim params: CLK_HZ=1000, TICK_HZ=100, DEB_TICKS=2, REP_TICKS=5, NCH=2)
// - Reset: RST_N low 3 cycles -> dac_org={32768,32768}, dac_width={27692,27692}, rpm_range=400, calib_*=0.
// - Debounce: SW7 glitch high 1 tick -> calib_org stays 0; SW7 high 3 ticks -> calib_org=1, CAL_ORG.
// - Single/repeat: CAL_ORG, CH_SEL=1, BTN_UP held 10 ticks -> ch1 org 32768 -> 32769 then +1/tick after 5 ticks, ch0 unchanged; one cal_step per increment.
// - Saturation: CAL_WID ch0 with org=37768, hold UP -> width stops at 27767 (sum 65535), cal_step silent; with CAL_WRAP_EN org at 37768 +1 -> 27768.
// - Both buttons: UP and DN held together 10 ticks -> no value change, no cal_step.
// - rpm_range: {SW6,SW5}=01,{SW4,SW3}=10 -> 5000; then {SW6,SW5}=10 -> stays 5000; RST_N low mid-hold -> all defaults.

Source files
------------

// File: rtl/sw_calib_ctrl.sv
// sw_calib_ctrl: front-panel switch/button controller for DAC calibration
// and encoder RPM-range selection. Debounces SW[7:0]/BTN_UP/BTN_DN, runs the
// calibration mode FSM and steps the per-channel origin / 10V-width codes
// with auto-repeat and bound checking.
// Optional feature macro: CAL_WRAP_EN (span bounds wrap instead of saturate).
module sw_calib_ctrl #(
  parameter int NCH       = 2,
  parameter int DAC_W     = 16,
  parameter int CLK_HZ    = 60000000,
  parameter int TICK_HZ   = 1000,
  parameter int DEB_TICKS = 20,
  parameter int REP_TICKS = 500,
  parameter int ORG_DEF   = 32768,
  parameter int WID_DEF   = 27692,
  parameter int CAL_SPAN  = 5000,
  parameter int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 CLK_60,
  input  logic                 RST_N,
  input  logic [7:0]           SW,
  input  logic                 BTN_UP,
  input  logic                 BTN_DN,
  input  logic [CH_W-1:0]      CH_SEL,
  output logic [NCH*DAC_W-1:0] dac_org,
  output logic [NCH*DAC_W-1:0] dac_width,
  output logic [15:0]          rpm_range,
  output logic                 calib_org,
  output logic                 calib_10V,
  output logic                 cal_step
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TC_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DC_W     = $clog2(DEB_TICKS + 1);
  localparam int RC_W     = $clog2(REP_TICKS + 1);
  localparam int NIN      = 10;
  localparam logic [DAC_W:0]  ORG_LO  = (DAC_W+1)'(ORG_DEF - CAL_SPAN);
  localparam logic [DAC_W:0]  ORG_HI  = (DAC_W+1)'(ORG_DEF + CAL_SPAN);
  localparam logic [DAC_W:0]  WID_LO  = (DAC_W+1)'(WID_DEF - CAL_SPAN);
  localparam logic [DAC_W:0]  WID_HI  = (DAC_W+1)'(WID_DEF + CAL_SPAN);
  localparam logic [DAC_W:0]  SUM_MAX = {1'b0, {DAC_W{1'b1}}};
  localparam logic [CH_W-1:0] CH_MAX  = CH_W'(NCH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CAL_ORG = 2'd1, CAL_WID = 2'd2} state_t;

  logic [TC_W-1:0]  tick_cnt_q;
  logic             tick;
  logic [NIN-1:0]   raw, sync1_q, sync2_q, deb;
  state_t           state_q, state_d;
  logic             calib_org_q, calib_10v_q;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [RC_W-1:0]  rep_q, rep_d;
  logic             up_prev_q, dn_prev_q;
  logic             req_v_q, req_v_d, req_up_q, req_wid_q;
  logic [DAC_W-1:0] org_q [NCH];
  logic [DAC_W-1:0] wid_q [NCH];
  logic [15:0]      rpm_q, rpm_d;
  logic             cal_step_q;
  logic             btn_up, btn_dn, entry;
  logic [DAC_W:0]   cur, oth, lo, hi, cand;
  logic             drop, do_step;
  logic             spare_unused;

  assign raw    = {BTN_DN, BTN_UP, SW};
  assign tick   = (tick_cnt_q == TC_W'(TICK_DIV - 1));
  assign btn_up = deb[8];
  assign btn_dn = deb[9];
  // SW1/SW2 are conditioned like the rest but have no consumer yet.
  assign spare_unused = &{1'b0, deb[1:0]};

  // Free-running divider producing the step/debounce tick.
  always_ff @(posedge CLK_60) begin
    if (!RST_N)    tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + TC_W'(1);
  end

  // Two-flop synchroniser for all raw front-panel inputs.
  always_ff @(posedge CLK_60) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < NIN; gi++) begin : g_deb
    logic [DC_W-1:0] cnt_q;
    logic            deb_q;
    // Accept a new level only after DEB_TICKS consecutive mismatching ticks.
    always_ff @(posedge CLK_60) begin
      if (!RST_N) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else if (tick) begin
        if (sync2_q[gi] != deb_q) begin
          if (cnt_q == DC_W'(DEB_TICKS - 1)) begin
            deb_q <= sync2_q[gi];
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + DC_W'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
    assign deb[gi] = deb_q;
  end

  // Mode decode from {SW8,SW7}, channel latch on entry, step request generation.
  always_comb begin
    state_d = IDLE;
    case ({deb[7], deb[6]})
      2'b01:   state_d = CAL_ORG;
      2'b11:   state_d = CAL_WID;
      default: state_d = IDLE;
    endcase
    entry = (state_d != IDLE) && (state_d != state_q);
    ch_d  = ch_q;
    if (entry) ch_d = (CH_SEL > CH_MAX) ? CH_MAX : CH_SEL;

    rep_d   = rep_q;
    req_v_d = 1'b0;
    if (!(btn_up ^ btn_dn)) begin
      rep_d = '0;
    end else if ((btn_up && !up_prev_q) || (btn_dn && !dn_prev_q)) begin
      rep_d   = '0;
      req_v_d = 1'b1;
    end else if (tick) begin
      if (rep_q == RC_W'(REP_TICKS)) req_v_d = 1'b1;
      else                           rep_d   = rep_q + RC_W'(1);
    end
    if (state_q == IDLE) req_v_d = 1'b0;
    if (entry)           rep_d   = '0;
  end

  // Candidate value for the pending step, checked against span and sum bounds.
  always_comb begin
    cur  = req_wid_q ? {1'b0, wid_q[ch_q]} : {1'b0, org_q[ch_q]};
    oth  = req_wid_q ? {1'b0, org_q[ch_q]} : {1'b0, wid_q[ch_q]};
    lo   = req_wid_q ? WID_LO : ORG_LO;
    hi   = req_wid_q ? WID_HI : ORG_HI;
    cand = cur;
    drop = 1'b0;
    if (req_up_q) begin
      if (cur >= hi) begin
`ifdef CAL_WRAP_EN
        cand = lo;
`else
        drop = 1'b1;
`endif
      end else begin
        cand = cur + (DAC_W+1)'(1);
      end
    end else begin
      if (cur <= lo) begin
`ifdef CAL_WRAP_EN
        cand = hi;
`else
        drop = 1'b1;
`endif
      end else begin
        cand = cur - (DAC_W+1)'(1);
      end
    end
    do_step = req_v_q && !drop && ((cand + oth) <= SUM_MAX) && (cand != cur);
  end

  // RPM full-scale table from {SW6,SW5},{SW4,SW3}; {SW6,SW5}=1x holds.
  always_comb begin
    rpm_d = rpm_q;
    if (!deb[5]) begin
      case ({deb[4], deb[3], deb[2]})
        3'b000: rpm_d = 16'd400;
        3'b001: rpm_d = 16'd900;
        3'b010: rpm_d = 16'd1800;
        3'b011: rpm_d = 16'd3600;
        3'b100: rpm_d = 16'd1250;
        3'b101: rpm_d = 16'd2500;
        3'b110: rpm_d = 16'd5000;
        3'b111: rpm_d = 16'd10000;
      endcase
    end
  end

  // Mode/step bookkeeping and calibration value registers.
  always_ff @(posedge CLK_60) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      calib_org_q <= 1'b0;
      calib_10v_q <= 1'b0;
      ch_q        <= '0;
      rep_q       <= '0;
      up_prev_q   <= 1'b0;
      dn_prev_q   <= 1'b0;
      req_v_q     <= 1'b0;
      req_up_q    <= 1'b0;
      req_wid_q   <= 1'b0;
      rpm_q       <= 16'd400;
      cal_step_q  <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        org_q[k] <= DAC_W'(ORG_DEF);
        wid_q[k] <= DAC_W'(WID_DEF);
      end
    end else begin
      state_q     <= state_d;
      calib_org_q <= (state_d == CAL_ORG);
      calib_10v_q <= (state_d == CAL_WID);
      ch_q        <= ch_d;
      rep_q       <= rep_d;
      up_prev_q   <= btn_up;
      dn_prev_q   <= btn_dn;
      req_v_q     <= req_v_d;
      req_up_q    <= btn_up;
      req_wid_q   <= (state_q == CAL_WID);
      rpm_q       <= rpm_d;
      cal_step_q  <= do_step;
      if (do_step) begin
        if (req_wid_q) wid_q[ch_q] <= cand[DAC_W-1:0];
        else           org_q[ch_q] <= cand[DAC_W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_pack
    assign dac_org[gi*DAC_W +: DAC_W]   = org_q[gi];
    assign dac_width[gi*DAC_W +: DAC_W] = wid_q[gi];
  end

  assign rpm_range = rpm_q;
  assign calib_org = calib_org_q;
  assign calib_10V = calib_10v_q;
  assign cal_step  = cal_step_q;

endmodule
